swap_engine: RTL and testbench

- Responder side of the memory-swap interface: accepts a swap command (two addresses) over a valid/ready handshake and exchanges the two entries of a small register file through a temp register.
- Uses a fixed 4-state walk and exports the phase code and internal write strobe.
- Sits between the host/control logic that issues swap commands and the register storage.
- Provides a host write port and a read port while idle.

---
 rtl/swap_pkg.sv | 17 +
 rtl/swap_regfile.sv | 39 +++
 rtl/swap_engine.sv | 138 +++++++++++++
 tb/tb_swap_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/swap_pkg.sv
// Shared definitions for the swap engine: state encoding and default widths.
package swap_pkg;

  // Default widths used when the engine is instantiated without overrides.
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;
  localparam int CW_DEF = 8;

  // The phase output exports these codes directly, so their values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MOVE  = 2'd2,
    STORE = 2'd3
  } swap_state_t;

endpackage

// File: rtl/swap_regfile.sv
// Small register file behind the swap engine: one synchronous write port,
// three combinational read ports, and a full clear on asynchronous reset.
module swap_regfile #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_host_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_host_o,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Storage: cleared on reset so an aborted swap leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_host_o = mem_q[raddr_host_i];
  assign rdata_a_o    = mem_q[raddr_a_i];
  assign rdata_b_o    = mem_q[raddr_b_i];

endmodule

// File: rtl/swap_engine.sv
// Swap engine: accepts a two-address swap command and exchanges the two
// register-file entries through a temp register in a fixed
// IDLE -> LOAD -> MOVE -> STORE walk. Hosts may write and read while idle.
module swap_engine
  import swap_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [1:0]    phase,
  output logic          int_we,
  output logic          done,
  output logic [CW-1:0] swap_cnt
);

  swap_state_t   state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [AW-1:0] b_q, b_d;
  logic [DW-1:0] temp_q, temp_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  swap_regfile #(
    .DW (DW),
    .AW (AW)
  ) u_regfile (
    .clk          (clk),
    .reset_n      (reset_n),
    .we_i         (mem_we),
    .waddr_i      (mem_waddr),
    .wdata_i      (mem_wdata),
    .raddr_host_i (rd_addr),
    .raddr_a_i    (a_q),
    .raddr_b_i    (b_q),
    .rdata_host_o (rd_data),
    .rdata_a_o    (rd_a),
    .rdata_b_o    (rd_b)
  );

  // State register for the swap walk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched addresses, temp copy, done pulse, swap count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      temp_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      temp_q <= temp_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic; the single write port is shared between the host (IDLE
  // only), the MOVE step (mem[a] <= mem[b]) and the STORE step (mem[b] <= temp).
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    temp_d    = temp_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;

    case (state_q)
      IDLE: begin
        mem_we = wr_en;
        if (req_valid) begin
          a_d     = addr_a;
          b_d     = addr_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        temp_d  = rd_a;
        state_d = MOVE;
      end
      MOVE: begin
        mem_we    = 1'b1;
        mem_waddr = a_q;
        mem_wdata = rd_b;
        state_d   = STORE;
      end
      STORE: begin
        mem_we    = 1'b1;
        mem_waddr = b_q;
        mem_wdata = temp_q;
        done_d    = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign phase     = state_q;
  assign int_we    = (state_q == MOVE) || (state_q == STORE);
  assign done      = done_q;
  assign swap_cnt  = cnt_q;

endmodule

// File: tb/tb_swap_engine.sv
// Directed bench for swap_engine: a table of per-cycle vectors for the basic
// swap plus hand-written sequences for back-to-back, same-cycle write,
// mid-swap reset and counter wrap.
module tb_swap_engine;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] addr_a;
  logic [1:0] addr_b;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [1:0] phase;
  logic       int_we;
  logic       done;
  logic [7:0] swap_cnt;

  int testsRun;
  int testsFailed;

  typedef struct {
    string      name;
    logic       reqValid;
    logic [1:0] a;
    logic [1:0] b;
    logic       wrEn;
    logic [1:0] wrAddr;
    logic [7:0] wrData;
    logic [1:0] expPhase;
    logic       expIntWe;
    logic       expDone;
    logic       expReady;
  } vec_t;

  vec_t vecs [5];

  swap_engine #(
    .DW (8),
    .AW (2),
    .CW (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .phase     (phase),
    .int_we    (int_we),
    .done      (done),
    .swap_cnt  (swap_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [1:0] a, input logic [1:0] b,
                               input logic we, input logic [1:0] wa, input logic [7:0] wd);
    req_valid = rv;
    addr_a    = a;
    addr_b    = b;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  task automatic checkMem(input string name, input logic [1:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    checkOutput(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic hostWrite(input logic [1:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, addr, data);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic runSwap(input logic [1:0] a, input logic [1:0] b);
    applyStimulus(1'b1, a, b, 1'b0, 2'd0, 8'h00);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    tick();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset_n     = 1'b0;
    rd_addr     = 2'd0;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);

    // Reset state
    #23;
    reset_n = 1'b1;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset phase", 32'(phase), 32'd0);
    checkOutput("reset int_we", 32'(int_we), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset swap_cnt", 32'(swap_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkMem($sformatf("reset mem[%0d]", i), 2'(i), 8'h00);
    end

    // Basic swap (0,3) with a host write to addr 2 dropped during MOVE
    hostWrite(2'd0, 8'hA5);
    hostWrite(2'd3, 8'h3C);
    vecs[0] = '{"accept", 1'b1, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"load",   1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"move",   1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"store",  1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"idle",   1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].reqValid, vecs[i].a, vecs[i].b,
                    vecs[i].wrEn, vecs[i].wrAddr, vecs[i].wrData);
      tick();
      checkOutput($sformatf("%s phase", vecs[i].name), 32'(phase), 32'(vecs[i].expPhase));
      checkOutput($sformatf("%s int_we", vecs[i].name), 32'(int_we), 32'(vecs[i].expIntWe));
      checkOutput($sformatf("%s done", vecs[i].name), 32'(done), 32'(vecs[i].expDone));
      checkOutput($sformatf("%s req_ready", vecs[i].name), 32'(req_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("%s busy", vecs[i].name), 32'(busy), 32'(!vecs[i].expReady));
    end
    checkMem("swap03 mem[0]", 2'd0, 8'h3C);
    checkMem("swap03 mem[3]", 2'd3, 8'hA5);
    checkMem("dropped write mem[2]", 2'd2, 8'h00);
    checkOutput("swap03 swap_cnt", 32'(swap_cnt), 32'd1);

    // Back-to-back swaps with req_valid held high
    hostWrite(2'd0, 8'h11);
    hostWrite(2'd1, 8'h22);
    hostWrite(2'd2, 8'h33);
    hostWrite(2'd3, 8'h44);
    applyStimulus(1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("b2b first accept phase", 32'(phase), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("b2b done cycle done", 32'(done), 32'd1);
    checkOutput("b2b done cycle ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("b2b second accept phase", 32'(phase), 32'd1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("b2b second done", 32'(done), 32'd1);
    checkMem("b2b mem[0]", 2'd0, 8'h22);
    checkMem("b2b mem[1]", 2'd1, 8'h33);
    checkMem("b2b mem[2]", 2'd2, 8'h11);
    checkMem("b2b mem[3]", 2'd3, 8'h44);
    checkOutput("b2b swap_cnt", 32'(swap_cnt), 32'd3);

    // Host write and accept on the same edge: LOAD sees the new value
    hostWrite(2'd2, 8'h10);
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b1, 2'd1, 8'h77);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("wr+accept done", 32'(done), 32'd1);
    checkMem("wr+accept mem[1]", 2'd1, 8'h10);
    checkMem("wr+accept mem[2]", 2'd2, 8'h77);
    checkOutput("wr+accept swap_cnt", 32'(swap_cnt), 32'd4);

    // Reset asserted during MOVE aborts everything immediately
    applyStimulus(1'b1, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    tick();
    checkOutput("pre-reset phase", 32'(phase), 32'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset phase", 32'(phase), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset swap_cnt", 32'(swap_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkMem($sformatf("midreset mem[%0d]", i), 2'(i), 8'h00);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Self-swap a=b=2 leaves data unchanged but still counts
    hostWrite(2'd2, 8'h5A);
    runSwap(2'd2, 2'd2);
    checkOutput("self-swap done", 32'(done), 32'd1);
    checkMem("self-swap mem[2]", 2'd2, 8'h5A);
    checkOutput("self-swap swap_cnt", 32'(swap_cnt), 32'd1);

    // Counter wraps from 255 back to 0 after 255 more swaps
    for (int i = 0; i < 254; i++) begin
      runSwap(2'd0, 2'd1);
    end
    checkOutput("cnt at 255", 32'(swap_cnt), 32'd255);
    runSwap(2'd0, 2'd1);
    checkOutput("cnt wrap", 32'(swap_cnt), 32'd0);
    checkOutput("cnt wrap done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
